// File: rtl/ifu_pkg.sv
// ifu_pkg: shared FSM state encoding and default parameters for the instruction fetch unit
package ifu_pkg;
  localparam int FIFO_WIDTH_DEF  = 32;
  localparam int ADDR_WIDTH_DEF  = 32;
  localparam int FIFO_LENGTH_DEF = 16;
  localparam int BURST_LEN_DEF   = 4;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;
endpackage

// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: issues credit-checked memory bursts and streams returned beats into ifu_fifo
module ifu_fetch_ctrl
  import ifu_pkg::*;
#(
  parameter int FIFO_WIDTH  = FIFO_WIDTH_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int FIFO_LENGTH = FIFO_LENGTH_DEF,
  parameter int BURST_LEN   = BURST_LEN_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] flush_addr,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic                  mem_rvalid,
  input  logic [FIFO_WIDTH-1:0] mem_rdata,
  output logic                  fifo_wr_en,
  output logic [FIFO_WIDTH-1:0] fifo_wr_data,
  input  logic                  fifo_full,
  input  logic                  fifo_pop,
  output logic                  busy,
  output logic                  overflow_err
);
  localparam int OW = $clog2(FIFO_LENGTH) + 1;
  localparam int BW = $clog2(BURST_LEN) + 1;
  localparam logic [OW-1:0] OCC_MAX = OW'(FIFO_LENGTH - 1 - BURST_LEN);
  localparam logic [BW-1:0] LAST = BW'(BURST_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(BURST_LEN * FIFO_WIDTH / 8);
  logic [1:0] state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d, mem_addr_q, mem_addr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [BW-1:0] beat_q, beat_d;
  logic flush_pending_q, flush_pending_d, overflow_q, overflow_d;
  logic in_burst, last_beat;
  assign in_burst = state_q == S_DATA || state_q == S_DRAIN;
  assign last_beat = mem_rvalid && beat_q == LAST;
  assign mem_req = state_q == S_REQ;
  assign mem_addr = mem_addr_q;
  assign fifo_wr_en = state_q == S_DATA && mem_rvalid;
  assign fifo_wr_data = fifo_wr_en ? mem_rdata : '0;
  assign busy = state_q != S_IDLE;
  assign overflow_err = overflow_q;
  always_comb begin
    state_d = state_q;
    fetch_addr_d = fetch_addr_q;
    mem_addr_d = mem_addr_q;
    flush_pending_d = flush_pending_q;
    case (state_q)
      S_IDLE: begin
        if (flush) fetch_addr_d = flush_addr;
        else if (start) fetch_addr_d = start_addr;
        else if (enable && occ_q <= OCC_MAX) begin
          state_d = S_REQ;
          mem_addr_d = fetch_addr_q;
        end
      end
      S_REQ: begin
        // mem_addr_q is held for the handshake; only the next fetch address is redirected
        if (flush) begin
          fetch_addr_d = flush_addr;
          flush_pending_d = 1'b1;
        end
        if (mem_ack) state_d = (flush || flush_pending_q) ? S_DRAIN : S_DATA;
      end
      S_DATA: begin
        if (flush) begin
          fetch_addr_d = flush_addr;
          state_d = last_beat ? S_IDLE : S_DRAIN;
        end else if (last_beat) begin
          fetch_addr_d = fetch_addr_q + STRIDE;
          state_d = S_IDLE;
        end
      end
      default: begin
        if (flush) fetch_addr_d = flush_addr;
        if (last_beat) begin
          state_d = S_IDLE;
          flush_pending_d = 1'b0;
        end
      end
    endcase
    beat_d = (in_burst && mem_rvalid) ? (last_beat ? '0 : beat_q + BW'(1)) : beat_q;
    occ_d = (fifo_wr_en && !fifo_pop) ? occ_q + OW'(1) :
            (!fifo_wr_en && fifo_pop) ? occ_q - OW'(1) : occ_q;
    overflow_d = overflow_q || (fifo_wr_en && fifo_full);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      fetch_addr_q <= '0;
      mem_addr_q <= '0;
      occ_q <= '0;
      beat_q <= '0;
      flush_pending_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fetch_addr_q <= fetch_addr_d;
      mem_addr_q <= mem_addr_d;
      occ_q <= occ_d;
      beat_q <= beat_d;
      flush_pending_q <= flush_pending_d;
      overflow_q <= overflow_d;
    end
  end
endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// tb_ifu_fetch_ctrl: vector table of bursts plus hand sequences, FIFO writes checked against a queue
module tb_ifu_fetch_ctrl;
  typedef struct {
    bit do_start;
    logic [31:0] saddr;
    int ack_dly;
    logic [31:0] d0;
    int flush_at;
    logic [31:0] faddr;
    bit stray;
    logic [31:0] exp_addr;
  } vec_t;
  logic clk = 0, rst = 1, enable = 0, start = 0, flush = 0;
  logic mem_ack = 0, mem_rvalid = 0, fifo_full = 0, fifo_pop = 0;
  logic [31:0] start_addr = 0, flush_addr = 0, mem_rdata = 0;
  logic mem_req, fifo_wr_en, busy, overflow_err;
  logic [31:0] mem_addr, fifo_wr_data;
  int checks = 0, failures = 0, full_at = 0, occ_m = 0;
  logic [31:0] exp_q[$];
  vec_t tbl[6];
  ifu_fetch_ctrl #(.FIFO_WIDTH(32), .ADDR_WIDTH(32), .FIFO_LENGTH(16), .BURST_LEN(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .start_addr(start_addr),
    .flush(flush), .flush_addr(flush_addr), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full),
    .fifo_pop(fifo_pop), .busy(busy), .overflow_err(overflow_err)
  );
  always #5 clk = ~clk;
  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", nm, act, req);
    end
  endfunction
  always @(negedge clk)
    if (fifo_wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write got=%h expected=no write", fifo_wr_data);
      end else chk("wr_data", fifo_wr_data, exp_q.pop_front());
    end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      fifo_pop = 1;
    end
    cyc();
    fifo_pop = 0;
    occ_m -= n;
  endtask
  task automatic wait_req(output bit ok);
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (mem_req) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL req_timeout got=mem_req 0 expected=mem_req 1 within 30 cycles");
    end
  endtask
  task automatic run_burst(input vec_t v);
    bit ok;
    int w = 0;
    if (v.do_start) begin
      cyc();
      enable = 0;
      start = 1;
      start_addr = v.saddr;
      cyc();
      start = 0;
    end
    cyc();
    enable = 1;
    wait_req(ok);
    if (!ok) begin
      enable = 0;
      return;
    end
    chk("req_addr", mem_addr, v.exp_addr);
    for (int d = 0; d < v.ack_dly; d++) begin
      cyc();
      flush = v.flush_at == 0 && d == 0;
      flush_addr = v.faddr;
      start = v.stray && d == 0;
      start_addr = 32'hDEAD0000;
      @(negedge clk);
      chk("req_hold", mem_req ? mem_addr : 32'hFFFFFFFF, v.exp_addr);
    end
    cyc();
    flush = 0;
    start = 0;
    mem_ack = 1;
    enable = 0;
    cyc();
    mem_ack = 0;
    for (int b = 1; b <= 4; b++) begin
      mem_rvalid = 1;
      mem_rdata = v.d0 + 32'(b - 1);
      fifo_full = b == full_at;
      if (v.flush_at < 0 || b <= v.flush_at) begin
        exp_q.push_back(mem_rdata);
        w++;
      end
      cyc();
      mem_rvalid = 0;
      fifo_full = 0;
      if (b == v.flush_at) begin
        flush = 1;
        flush_addr = v.faddr;
        cyc();
        flush = 0;
      end
    end
    @(negedge clk);
    chk("idle_after_burst", {31'b0, busy}, 0);
    chk("writes_delivered", exp_q.size(), 0);
    occ_m += w;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end
  initial begin
    bit ok, seen;
    vec_t v;
    tbl[0] = '{1, 32'h1000, 2, 32'hA0, -1, 32'h0, 0, 32'h1000};
    tbl[1] = '{0, 32'h0, 1, 32'hB0, 2, 32'h2000, 1, 32'h1010};
    tbl[2] = '{0, 32'h0, 3, 32'hC0, 0, 32'h3000, 0, 32'h2000};
    tbl[3] = '{0, 32'h0, 1, 32'hD0, -1, 32'h0, 0, 32'h3000};
    tbl[4] = '{1, 32'hFFFFFFF0, 1, 32'hE0, -1, 32'h0, 0, 32'hFFFFFFF0};
    tbl[5] = '{0, 32'h0, 0, 32'hF0, -1, 32'h0, 0, 32'h00000000};
    repeat (3) @(negedge clk);
    chk("rst_mem_req", {31'b0, mem_req}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_wr_en", {31'b0, fifo_wr_en}, 0);
    chk("rst_overflow", {31'b0, overflow_err}, 0);
    cyc();
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      run_burst(tbl[i]);
      pop_n(occ_m);
    end
    cyc();
    start = 1;
    start_addr = 32'h5000;
    flush = 1;
    flush_addr = 32'h6000;
    cyc();
    start = 0;
    flush = 0;
    run_burst('{0, 32'h0, 1, 32'h60, -1, 32'h0, 0, 32'h6000});
    pop_n(occ_m);
    run_burst('{1, 32'h4000, 1, 32'h40, -1, 32'h0, 0, 32'h4000});
    run_burst('{0, 32'h0, 1, 32'h44, -1, 32'h0, 0, 32'h4010});
    run_burst('{0, 32'h0, 1, 32'h48, -1, 32'h0, 0, 32'h4020});
    cyc();
    enable = 1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (mem_req) seen = 1;
    end
    chk("credit_stall_occ12", {31'b0, seen}, 0);
    cyc();
    fifo_pop = 1;
    @(negedge clk);
    chk("credit_pop_cycle", {31'b0, mem_req}, 0);
    cyc();
    fifo_pop = 0;
    occ_m--;
    cyc();
    @(negedge clk);
    chk("credit_release_req", {31'b0, mem_req}, 1);
    run_burst('{0, 32'h0, 1, 32'h4C, -1, 32'h0, 0, 32'h4030});
    pop_n(occ_m);
    full_at = 2;
    run_burst('{0, 32'h0, 1, 32'h50, -1, 32'h0, 0, 32'h4040});
    full_at = 0;
    chk("overflow_set", {31'b0, overflow_err}, 1);
    pop_n(occ_m);
    run_burst('{0, 32'h0, 1, 32'h54, -1, 32'h0, 0, 32'h4050});
    chk("overflow_sticky", {31'b0, overflow_err}, 1);
    pop_n(occ_m);
    cyc();
    enable = 1;
    wait_req(ok);
    chk("rstmid_req_addr", mem_addr, 32'h4060);
    cyc();
    mem_ack = 1;
    enable = 0;
    cyc();
    mem_ack = 0;
    mem_rvalid = 1;
    mem_rdata = 32'h77;
    exp_q.push_back(32'h77);
    cyc();
    mem_rdata = 32'h78;
    rst = 1;
    #1;
    chk("rstmid_mem_req", {31'b0, mem_req}, 0);
    chk("rstmid_mem_addr", mem_addr, 0);
    chk("rstmid_wr_en", {31'b0, fifo_wr_en}, 0);
    chk("rstmid_wr_data", fifo_wr_data, 0);
    chk("rstmid_busy", {31'b0, busy}, 0);
    chk("rstmid_overflow", {31'b0, overflow_err}, 0);
    cyc();
    rst = 0;
    occ_m = 0;
    repeat (3) begin
      cyc();
      mem_rdata = mem_rdata + 1;
    end
    mem_rvalid = 0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (mem_req || busy) seen = 1;
    end
    chk("rstmid_no_fetch", {31'b0, seen}, 0);
    run_burst('{1, 32'h8000, 1, 32'h90, -1, 32'h0, 0, 32'h8000});
    pop_n(occ_m);
    chk("final_sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ifu_fetch_ctrl.md
IFU_FETCH_CTRL -- requirements
Module: ifu_fetch_ctrl

Interface
REQ-001 Parameters SHALL be:
- FIFO_WIDTH, default 32, instruction word width.
- ADDR_WIDTH, default 32, byte address width.
- FIFO_LENGTH, default 16, depth of the downstream ifu_fifo; usable capacity is FIFO_LENGTH-1.
- BURST_LEN, default 4, beats per memory burst; power of two, at most FIFO_LENGTH-1.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on its rising edge.
- rst, in, 1, asynchronous active-high reset.
- enable, in, 1, level; fetching permitted while high.
- start, in, 1, pulse; loads start_addr as the fetch address.
- start_addr, in, ADDR_WIDTH, initial fetch address.
- flush, in, 1, pulse; redirect to flush_addr.
- flush_addr, in, ADDR_WIDTH, redirect address.
- mem_req, out, 1, burst request.
- mem_addr, out, ADDR_WIDTH, burst byte address.
- mem_ack, in, 1, request accepted.
- mem_rvalid, in, 1, read beat valid.
- mem_rdata, in, FIFO_WIDTH, read beat data.
- fifo_wr_en, out, 1, FIFO write strobe.
- fifo_wr_data, out, FIFO_WIDTH, FIFO write data.
- fifo_full, in, 1, FIFO full flag.
- fifo_pop, in, 1, accepted FIFO read (fifo_rd_en and not fifo_empty).
- busy, out, 1, high in any state other than IDLE.
- overflow_err, out, 1, sticky error flag.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, REQ, DATA and DRAIN.
REQ-004 IDLE SHALL go to REQ when enable is high, no flush or start is in the same cycle, and occ <= FIFO_LENGTH-1-BURST_LEN.
REQ-005 In REQ, mem_req SHALL be 1 and mem_addr SHALL equal fetch_addr, both held stable until mem_ack; mem_req SHALL never drop before mem_ack.
REQ-006 REQ with mem_ack SHALL go to DATA, or to DRAIN if a flush is pending.
REQ-007 In DATA, each mem_rvalid SHALL produce a fifo_wr_en pulse with fifo_wr_data = mem_rdata in the same cycle (zero latency); mem_rvalid outside DATA and DRAIN SHALL be ignored.
REQ-008 On beat BURST_LEN, fetch_addr SHALL advance by BURST_LEN*FIFO_WIDTH/8 modulo 2^ADDR_WIDTH and the FSM SHALL return to IDLE.
REQ-009 occ SHALL be an internal counter of $clog2(FIFO_LENGTH)+1 bits:
- +1 on fifo_wr_en alone.
- -1 on fifo_pop alone.
- unchanged when both occur in the same cycle.
REQ-010 Flush handling SHALL depend on state:
- IDLE: fetch_addr <= flush_addr on the next edge.
- REQ: set flush_pending; fetch_addr <= flush_addr.
- DATA: fetch_addr <= flush_addr; go to DRAIN.
REQ-011 DRAIN SHALL count but never write the remaining beats of the burst, then go to IDLE and clear flush_pending.
REQ-012 A start pulse SHALL load start_addr into fetch_addr only in IDLE; in any other state it SHALL be ignored.
REQ-013 If flush and start occur in the same IDLE cycle, flush SHALL win.
REQ-014 Deasserting enable SHALL let an in-progress burst complete and SHALL block only new requests.
REQ-015 mem_rvalid with fifo_full in DATA SHALL set overflow_err, which clears only on reset; the beat SHALL still be presented with fifo_wr_en.

Reset
REQ-016 Asserting rst SHALL immediately force:
- state to IDLE;
- mem_req, fifo_wr_en, busy and overflow_err to 0;
- mem_addr, fifo_wr_data, fetch_addr, occ, the beat counter and flush_pending to 0.
REQ-017 Reset asserted mid-burst SHALL abandon the burst; the memory side is reset by the same rst.

Structure
REQ-018 The FSM state encoding and the default parameter values SHALL live in a shared package (ifu_pkg).
REQ-019 The block SHALL be a single module with no sub-modules; it connects directly to ifu_fifo.

Verification
Bench parameters are FIFO_WIDTH=32, FIFO_LENGTH=16, BURST_LEN=4.
REQ-020 Basic fetch: start with start_addr 0x1000, enable=1, mem_ack 2 cycles after mem_req, 4 beats 0xA0..0xA3 -> mem_addr=0x1000, four fifo_wr_en pulses carrying 0xA0..0xA3, next mem_addr=0x1010.
REQ-021 Credit stall: no pops -> three bursts, occ=12, no fourth mem_req; one fifo_pop -> occ=11 and mem_req asserts next cycle.
REQ-022 Flush in DATA: flush with flush_addr 0x2000 after beat 2 -> beats 3 and 4 produce no fifo_wr_en; next mem_addr=0x2000.
REQ-023 Flush in REQ: flush before mem_ack -> mem_addr stays 0x1000 until ack; all 4 beats are discarded; next mem_addr=0x2000.
REQ-024 Overflow: force fifo_full=1 during a beat -> overflow_err=1 and stays 1 until rst.
REQ-025 Reset mid-burst: assert rst after beat 1 -> all outputs are 0 immediately; after release, nothing is fetched until the next start/enable.
